// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI arbiter: FSM state encoding,
// replay frame lengths and the default inter-frame gap.
package mcu_spi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_EE_SETUP,
        ST_EE_SHIFT,
        ST_EE_TAIL,
        ST_HOST_SETUP,
        ST_HOST_SHIFT,
        ST_HOST_TAIL,
        ST_HOST_HOLD,
        ST_GAP
    } arb_state_t;

    localparam int FRAME_LEN_SHORT    = 16;
    localparam int FRAME_LEN_LONG     = 32;
    localparam int HOST_BITS          = 8;
    localparam int GAP_CYCLES_DEFAULT = 2;

    function automatic logic frame_len_ok(input logic [5:0] cnt);
        return (cnt == 6'(FRAME_LEN_SHORT)) || (cnt == 6'(FRAME_LEN_LONG));
    endfunction

endpackage

// File: rtl/mcu_spi_arbiter_if.sv
// Bundle of the EEPROM mirror stream, host byte port, error flags and MCU SPI
// link; slave is the arbiter's view, master is the surrounding system's view.
interface mcu_spi_arbiter_if;

    logic       EepromSPIDo;
    logic       EepromSPISel;
    logic       EepromSPIClkRunning;
    logic       MCUReady;
    logic       MCUReadyFallingEdge;
    logic       HostStart;
    logic [7:0] HostTxData;
    logic       HostHold;
    logic       HostBusy;
    logic       HostDone;
    logic [7:0] HostRxData;
    logic       ErrClear;
    logic       EepromOverrun;
    logic       HostSelLost;
    logic       MCUSPIDo;
    logic       MCUSPISel;
    logic       MCUSPIClkEn;
    logic       MCUSPIDi;

    modport slave (
        input  EepromSPIDo, EepromSPISel, EepromSPIClkRunning, MCUReady,
        input  HostStart, HostTxData, HostHold, ErrClear, MCUSPIDi,
        output MCUReadyFallingEdge, HostBusy, HostDone, HostRxData,
        output EepromOverrun, HostSelLost, MCUSPIDo, MCUSPISel, MCUSPIClkEn
    );

    modport master (
        output EepromSPIDo, EepromSPISel, EepromSPIClkRunning, MCUReady,
        output HostStart, HostTxData, HostHold, ErrClear, MCUSPIDi,
        input  MCUReadyFallingEdge, HostBusy, HostDone, HostRxData,
        input  EepromOverrun, HostSelLost, MCUSPIDo, MCUSPISel, MCUSPIClkEn
    );

endinterface

// File: rtl/mcu_ready_sync.sv
// Two-flop synchroniser for the asynchronous MCU ready pin with a registered
// falling-edge pulse. The chain resets to 1 so reset release never looks like a fall.
module mcu_ready_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic fall
);

    logic meta;
    logic sync;
    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            last <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            last <= sync;
            fall <= last & ~sync;
        end
    end

    assign level = sync;

endmodule

// File: rtl/mcu_spi_arbiter.sv
// Store-and-forward replay of EEPROM mirror frames onto the shared MCU SPI link,
// interleaved with host byte transfers; all link outputs are registered.
//
// state      | meaning
// IDLE       | link released, waiting for a pending frame or a host request
// EE_SETUP   | Sel low one cycle before the EEPROM replay
// EE_SHIFT   | 16 or 32 replay bits, clock enabled
// EE_TAIL    | Sel low one cycle after the last replay bit
// HOST_SETUP | Sel low one cycle before the host byte
// HOST_SHIFT | 8 host bits out, MCU bits in
// HOST_TAIL  | last MCU bit sampled, HostDone issued on exit
// HOST_HOLD  | Sel kept low between host bytes
// GAP        | Sel high for GAP_CYCLES before the link may be reused
module mcu_spi_arbiter
    import mcu_spi_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
    input  logic              SClk,
    input  logic              Reset,
    mcu_spi_arbiter_if.slave  bus
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t state;
    arb_state_t state_nxt;

    logic [31:0]      cap_sr;
    logic [5:0]       cap_cnt;
    logic [31:0]      pend_data;
    logic             pend_long;
    logic             pending;
    logic             frame_close;
    logic             frame_ok;

    logic [31:0]      sh;
    logic [4:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             hold_q;
    logic             host_shift_q;
    logic [7:0]       rx_sr;
    logic             ready_level;

    logic             take_pending;
    logic             accept_host;
    logic             sel_lost_set;
    logic             host_done;

    mcu_ready_sync u_ready_sync (
        .clk      (SClk),
        .rst      (Reset),
        .async_in (bus.MCUReady),
        .level    (ready_level),
        .fall     (bus.MCUReadyFallingEdge)
    );

    assign frame_close = bus.EepromSPISel && (cap_cnt != 6'd0);
    assign frame_ok    = frame_close && frame_len_ok(cap_cnt);

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            cap_sr  <= '0;
            cap_cnt <= '0;
        end else if (frame_close) begin
            cap_cnt <= '0;
        end else if (bus.EepromSPIClkRunning) begin
            cap_sr  <= {cap_sr[30:0], bus.EepromSPIDo};
            cap_cnt <= cap_cnt + 6'd1;
        end
    end

    // Short frames are left-aligned so the replay always shifts out of bit 31.
    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            pend_data <= '0;
            pend_long <= 1'b0;
            pending   <= 1'b0;
        end else if (frame_ok) begin
            pend_data <= (cap_cnt == 6'(FRAME_LEN_LONG)) ? cap_sr : {cap_sr[15:0], 16'h0000};
            pend_long <= (cap_cnt == 6'(FRAME_LEN_LONG));
            pending   <= 1'b1;
        end else if (take_pending) begin
            pending   <= 1'b0;
        end
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        take_pending = 1'b0;
        accept_host  = 1'b0;
        sel_lost_set = 1'b0;
        host_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    take_pending = 1'b1;
                    state_nxt    = ST_EE_SETUP;
                end else if (bus.HostStart && ready_level) begin
                    accept_host = 1'b1;
                    state_nxt   = ST_HOST_SETUP;
                end
            end
            ST_EE_SETUP:   state_nxt = ST_EE_SHIFT;
            ST_EE_SHIFT:   if (bit_cnt == 5'd0) state_nxt = ST_EE_TAIL;
            ST_EE_TAIL:    state_nxt = ST_GAP;
            ST_HOST_SETUP: state_nxt = ST_HOST_SHIFT;
            ST_HOST_SHIFT: if (bit_cnt == 5'd0) state_nxt = ST_HOST_TAIL;
            ST_HOST_TAIL: begin
                host_done = 1'b1;
                state_nxt = hold_q ? ST_HOST_HOLD : ST_GAP;
            end
            ST_HOST_HOLD: begin
                if (bus.HostStart) begin
                    accept_host = 1'b1;
                    state_nxt   = ST_HOST_SETUP;
                end else if (pending) begin
                    sel_lost_set = 1'b1;
                    state_nxt    = ST_GAP;
                end else if (!bus.HostHold) begin
                    state_nxt = ST_GAP;
                end
            end
            // A frame already waiting at the end of the gap starts directly,
            // so back-to-back frames see exactly GAP_CYCLES of Sel high.
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    if (pending) begin
                        take_pending = 1'b1;
                        state_nxt    = ST_EE_SETUP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            sh      <= '0;
            bit_cnt <= '0;
            hold_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            if (take_pending) begin
                sh      <= pend_data;
                bit_cnt <= pend_long ? 5'(FRAME_LEN_LONG - 1) : 5'(FRAME_LEN_SHORT - 1);
            end else if (accept_host) begin
                sh      <= {bus.HostTxData, {(32 - HOST_BITS){1'b0}}};
                bit_cnt <= 5'(HOST_BITS - 1);
                hold_q  <= bus.HostHold;
            end else if (state == ST_EE_SHIFT || state == ST_HOST_SHIFT) begin
                sh      <= {sh[30:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end

            if (state_nxt == ST_GAP && state != ST_GAP) begin
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if (state == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Link pins trail the state by one cycle; MCU data is therefore sampled
    // one cycle after each HOST_SHIFT state, at the edge ending the visible bit.
    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            bus.MCUSPISel   <= 1'b1;
            bus.MCUSPIClkEn <= 1'b0;
            bus.MCUSPIDo    <= 1'b0;
            host_shift_q    <= 1'b0;
            rx_sr           <= '0;
            bus.HostRxData  <= '0;
            bus.HostDone    <= 1'b0;
            bus.HostBusy    <= 1'b0;
        end else begin
            bus.MCUSPISel   <= (state == ST_IDLE) || (state == ST_GAP);
            bus.MCUSPIClkEn <= (state == ST_EE_SHIFT) || (state == ST_HOST_SHIFT);
            bus.MCUSPIDo    <= ((state == ST_EE_SHIFT) || (state == ST_HOST_SHIFT)) ? sh[31] : 1'b0;
            host_shift_q    <= (state == ST_HOST_SHIFT);
            if (host_shift_q) begin
                rx_sr <= {rx_sr[6:0], bus.MCUSPIDi};
            end
            bus.HostDone <= host_done;
            if (host_done) begin
                bus.HostRxData <= {rx_sr[6:0], bus.MCUSPIDi};
            end
            if (accept_host) begin
                bus.HostBusy <= 1'b1;
            end else if (host_done) begin
                bus.HostBusy <= 1'b0;
            end
        end
    end

    always_ff @(posedge SClk or posedge Reset) begin
        if (Reset) begin
            bus.EepromOverrun <= 1'b0;
            bus.HostSelLost   <= 1'b0;
        end else begin
            if (frame_ok && pending && !take_pending) begin
                bus.EepromOverrun <= 1'b1;
            end else if (bus.ErrClear) begin
                bus.EepromOverrun <= 1'b0;
            end
            if (sel_lost_set) begin
                bus.HostSelLost <= 1'b1;
            end else if (bus.ErrClear) begin
                bus.HostSelLost <= 1'b0;
            end
        end
    end

endmodule
